// File: rtl/adder_tree_pipe_if.sv
// adder_tree_pipe_if: operand-vector input and sum output handshakes of the
// pipelined adder tree. The result width follows the tree depth so that the
// full-width sum always fits.
interface adder_tree_pipe_if #(
  parameter int WIDTH = 16,
  parameter int N_OPS = 6
);
  localparam int LVL = $clog2(N_OPS);
  localparam int RW  = WIDTH + LVL;

  logic                   in_valid;
  logic [N_OPS*WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          result;
  logic                   overflow;

  // Producer/consumer side: presents operand vectors and consumes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  // Adder tree side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined unsigned binary adder tree over N_OPS operands.
// One register level per tree level (each one bit wider than the previous),
// followed by an output register that formats the sum as full width, wrapped
// or saturated. The whole pipeline advances as one unit when the output slot
// is empty or being consumed, so a stalled output freezes every stage.
module adder_tree_pipe #(
  parameter int WIDTH    = 16,
  parameter int N_OPS    = 6,
  parameter int OUT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  adder_tree_pipe_if.slave bus
);
  localparam int         LVL  = $clog2(N_OPS);
  localparam int         RW   = WIDTH + LVL;
  localparam logic [1:0] MODE = 2'(OUT_MODE);

  // Number of live elements at tree level lvl (level 0 = raw operands).
  function automatic int lvl_cnt(input int lvl);
    int c;
    c = N_OPS;
    for (int k = 0; k < lvl; k++) begin
      c = (c + 32'sd1) / 32'sd2;
    end
    return c;
  endfunction

  // Clamp a full-width sum to the largest WIDTH-bit value.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [RW-1:0] s);
    logic [WIDTH-1:0] r;
    if (|s[RW-1:WIDTH]) begin
      r = '1;
    end else begin
      r = s[WIDTH-1:0];
    end
    return r;
  endfunction

  logic           advance_s;
  logic [LVL:1]   valid_r;
  logic [RW-1:0]  full_s;
  logic [RW-1:0]  fmt_s;
  logic           ovf_s;
  logic           out_valid_r;
  logic [RW-1:0]  result_r;
  logic           overflow_r;

  assign advance_s     = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;

  // Tree levels: level i pairs neighbours of level i-1; a leftover odd
  // element is carried forward zero-extended.
  for (genvar i = 1; i <= LVL; i++) begin : g_lvl
    localparam int CNT  = lvl_cnt(i);
    localparam int PCNT = lvl_cnt(i - 1);
    localparam int W    = WIDTH + i;

    logic [W-1:0] sum_s  [CNT];
    logic [W-1:0] elem_r [CNT];

    for (genvar j = 0; j < CNT; j++) begin : g_elem
      if (i == 1) begin : g_leaf
        if (2 * j + 1 < PCNT) begin : g_pair
          assign sum_s[j] = {1'b0, bus.in_data[(2*j)*WIDTH +: WIDTH]}
                          + {1'b0, bus.in_data[(2*j+1)*WIDTH +: WIDTH]};
        end else begin : g_pass
          assign sum_s[j] = {1'b0, bus.in_data[(2*j)*WIDTH +: WIDTH]};
        end
      end else begin : g_node
        if (2 * j + 1 < PCNT) begin : g_pair
          assign sum_s[j] = {1'b0, g_lvl[i-1].elem_r[2*j]}
                          + {1'b0, g_lvl[i-1].elem_r[2*j+1]};
        end else begin : g_pass
          assign sum_s[j] = {1'b0, g_lvl[i-1].elem_r[2*j]};
        end
      end
    end

    // Level data register: captures the pairwise sums whenever the pipe moves.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < CNT; k++) begin
          elem_r[k] <= '0;
        end
      end else if (advance_s) begin
        elem_r <= sum_s;
      end
    end
  end

  // Stage valid chain: bubbles travel with the data and reset flushes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (advance_s) begin
      valid_r[1] <= bus.in_valid;
      for (int k = 2; k <= LVL; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  assign full_s = g_lvl[LVL].elem_r[0];

  // Output formatting and overflow detection for the selected mode.
  always_comb begin
    fmt_s = full_s;
    ovf_s = 1'b0;
    case (MODE)
      2'd0: begin
        fmt_s = full_s;
        ovf_s = 1'b0;
      end
      2'd1: begin
        fmt_s = {{LVL{1'b0}}, full_s[WIDTH-1:0]};
        ovf_s = |full_s[RW-1:WIDTH];
      end
      2'd2: begin
        fmt_s = {{LVL{1'b0}}, sat_fn(full_s)};
        ovf_s = |full_s[RW-1:WIDTH];
      end
      default: begin
        fmt_s = full_s;
        ovf_s = 1'b0;
      end
    endcase
  end

  // Output register: overflow is qualified by the valid bit so it never
  // shows up on an idle output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      overflow_r  <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= valid_r[LVL];
      result_r    <= fmt_s;
      overflow_r  <= valid_r[LVL] & ovf_s;
    end
  end
endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: directed bench for the pipelined adder tree. Three
// six-operand instances (one per output mode) share one stimulus stream;
// three- and two-operand instances cover the odd and minimum tree shapes.
module tb_adder_tree_pipe;
  logic clk = 1'b0;
  logic rst;

  logic        v6;
  logic [95:0] d6;
  logic        rdy6;
  logic        v3;
  logic [47:0] d3;
  logic        v2;
  logic [31:0] d2;

  int          errors = 0;
  int          checks = 0;
  logic [18:0] exp_q[$];
  int          got;
  bit          popped;
  int          first_c;
  int          last_c;
  logic [18:0] held;

  always #5 clk = ~clk;

  adder_tree_pipe_if #(.WIDTH(16), .N_OPS(6)) if0 (), if1 (), if2 ();
  adder_tree_pipe_if #(.WIDTH(16), .N_OPS(3)) if3 ();
  adder_tree_pipe_if #(.WIDTH(16), .N_OPS(2)) if4 ();

  assign if0.in_valid = v6;  assign if0.in_data = d6;  assign if0.out_ready = rdy6;
  assign if1.in_valid = v6;  assign if1.in_data = d6;  assign if1.out_ready = rdy6;
  assign if2.in_valid = v6;  assign if2.in_data = d6;  assign if2.out_ready = rdy6;
  assign if3.in_valid = v3;  assign if3.in_data = d3;  assign if3.out_ready = 1'b1;
  assign if4.in_valid = v2;  assign if4.in_data = d2;  assign if4.out_ready = 1'b1;

  adder_tree_pipe #(.WIDTH(16), .N_OPS(6), .OUT_MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(if0.slave));
  adder_tree_pipe #(.WIDTH(16), .N_OPS(6), .OUT_MODE(1)) u_m1 (.clk(clk), .rst(rst), .bus(if1.slave));
  adder_tree_pipe #(.WIDTH(16), .N_OPS(6), .OUT_MODE(2)) u_m2 (.clk(clk), .rst(rst), .bus(if2.slave));
  adder_tree_pipe #(.WIDTH(16), .N_OPS(3), .OUT_MODE(0)) u_n3 (.clk(clk), .rst(rst), .bus(if3.slave));
  adder_tree_pipe #(.WIDTH(16), .N_OPS(2), .OUT_MODE(0)) u_n2 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sum of six 16-bit operands.
  function automatic logic [18:0] sum6(input logic [95:0] d);
    logic [18:0] s;
    s = 19'd0;
    for (int k = 0; k < 6; k++) begin
      s = s + {3'b000, d[k*16 +: 16]};
    end
    return s;
  endfunction

  // One clock with scoreboard: record accepted vectors, compare consumed results.
  task automatic cycle();
    #1;
    popped = 1'b0;
    if (v6 && if0.in_ready) begin
      exp_q.push_back(sum6(d6));
    end
    if (if0.out_valid && rdy6) begin
      check("sb_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("sb_data", 64'(if0.result), 64'(exp_q.pop_front()));
      end
      popped = 1'b1;
      got++;
    end
    @(posedge clk);
    #1;
  endtask

  // Single vector through all three six-operand instances with LAT = 4.
  task automatic run6(input string tag, input logic [95:0] d,
                      input logic [18:0] e0, input logic [18:0] e1, input logic [18:0] e2,
                      input logic o0, input logic o1, input logic o2);
    v6 = 1'b1;
    d6 = d;
    tick();
    v6 = 1'b0;
    d6 = {3{32'hDEADBEEF}};
    for (int k = 1; k < 4; k++) begin
      check({tag, "_early"}, 64'(if0.out_valid), 64'd0);
      tick();
    end
    check({tag, "_valid"}, 64'({if0.out_valid, if1.out_valid, if2.out_valid}), 64'd7);
    check({tag, "_res_m0"}, 64'(if0.result), 64'(e0));
    check({tag, "_res_m1"}, 64'(if1.result), 64'(e1));
    check({tag, "_res_m2"}, 64'(if2.result), 64'(e2));
    check({tag, "_ovf"}, 64'({if0.overflow, if1.overflow, if2.overflow}), 64'({o0, o1, o2}));
    tick();
    check({tag, "_idle"}, 64'({if0.out_valid, if0.overflow, if1.overflow, if2.overflow}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; rdy6 = 1'b1;
    v6 = 1'b0; d6 = '0; v3 = 1'b0; d3 = '0; v2 = 1'b0; d2 = '0;
    tick();
    tick();
    check("rst_valid", 64'(if0.out_valid), 64'd0);
    check("rst_result", 64'(if0.result), 64'd0);
    check("rst_ovf", 64'({if1.overflow, if2.overflow}), 64'd0);

    // A vector offered while reset is high must be ignored.
    v6 = 1'b1; d6 = {6{16'd1}};
    tick();
    rst = 1'b0; v6 = 1'b0;
    #1;
    check("ready_after_rst", 64'(if0.in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("no_accept_in_rst", 64'(if0.out_valid), 64'd0);
    end

    // Directed sums across the three output modes.
    run6("basic", {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0},
         19'd15, 19'd15, 19'd15, 1'b0, 1'b0, 1'b0);
    run6("allff", {6{16'hFFFF}},
         19'h5FFFA, 19'h0FFFA, 19'h0FFFF, 1'b0, 1'b1, 1'b1);
    run6("edge_ffff", {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF},
         19'h0FFFF, 19'h0FFFF, 19'h0FFFF, 1'b0, 1'b0, 1'b0);
    run6("edge_10000", {16'd0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h8000},
         19'h10000, 19'h00000, 19'h0FFFF, 1'b0, 1'b1, 1'b1);

    // Back-to-back random vectors: ten results, in order, no gaps.
    exp_q.delete(); got = 0; first_c = -1; last_c = -1; rdy6 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin
        v6 = 1'b1;
        d6 = {$urandom(), $urandom(), $urandom()};
      end else begin
        v6 = 1'b0;
      end
      cycle();
      if (popped) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    check("b2b_count", 64'(got), 64'd10);
    check("b2b_first_lat", 64'(first_c), 64'd4);
    check("b2b_no_gap", 64'(last_c - first_c), 64'd9);

    // Backpressure with the pipeline full.
    exp_q.delete(); got = 0; rdy6 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      v6 = 1'b1;
      d6 = {$urandom(), $urandom(), $urandom()};
      cycle();
    end
    check("bp_full", 64'(if0.out_valid), 64'd1);
    rdy6 = 1'b0;
    held = if0.result;
    for (int s = 0; s < 5; s++) begin
      v6 = 1'b1;
      d6 = {$urandom(), $urandom(), $urandom()};
      cycle();
      check("bp_ready", 64'(if0.in_ready), 64'd0);
      check("bp_valid", 64'(if0.out_valid), 64'd1);
      check("bp_hold", 64'(if0.result), 64'(held));
    end
    rdy6 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 3) begin
        v6 = 1'b1;
        d6 = {$urandom(), $urandom(), $urandom()};
      end else begin
        v6 = 1'b0;
      end
      cycle();
    end
    check("bp_delivered", 64'(got), 64'd7);
    check("bp_leftover", 64'(exp_q.size()), 64'd0);

    // Reset one cycle before the first of three in-flight results emerges.
    for (int c = 0; c < 3; c++) begin
      v6 = 1'b1;
      d6 = {$urandom(), $urandom(), $urandom()};
      tick();
    end
    v6 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rmf_idle", 64'(if0.out_valid), 64'd0);
      tick();
    end
    run6("rmf_new", {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
         19'd210, 19'd210, 19'd210, 1'b0, 1'b0, 1'b0);

    // Odd operand count: LAT = 3.
    v3 = 1'b1; d3 = {16'd4, 16'd2, 16'd1};
    tick();
    v3 = 1'b0; d3 = {3{16'hBEEF}};
    for (int k = 1; k < 3; k++) begin
      check("n3_early", 64'(if3.out_valid), 64'd0);
      tick();
    end
    check("n3_valid", 64'(if3.out_valid), 64'd1);
    check("n3_result", 64'(if3.result), 64'd7);
    check("n3_ovf", 64'(if3.overflow), 64'd0);

    // Minimum operand count: LAT = 2.
    v2 = 1'b1; d2 = {16'd1, 16'hFFFF};
    tick();
    v2 = 1'b0; d2 = {2{16'h1234}};
    check("n2_early", 64'(if4.out_valid), 64'd0);
    tick();
    check("n2_valid", 64'(if4.out_valid), 64'd1);
    check("n2_result", 64'(if4.result), 64'h10000);
    check("n2_ovf", 64'(if4.overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 The block SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 16: width of each unsigned operand, range 4..64.
REQ-003 Parameter N_OPS, default 6: operand count, range 2..64.
REQ-004 Parameter OUT_MODE, default 0: 0 = full width, 1 = wrap to WIDTH, 2 = saturate to WIDTH.
REQ-005 Derived constants: LVL = $clog2(N_OPS); RW = WIDTH + LVL; LAT = LVL + 1.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  in_data holds a valid operand vector.
REQ-009 in_data  input  N_OPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_ready  output  1  block accepts a vector this cycle.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 result  output  RW  sum of the operand vector, formatted per OUT_MODE.
REQ-014 overflow  output  1  full sum is >= 2**WIDTH; constant 0 when OUT_MODE = 0.

Function
REQ-015 Operands SHALL be summed unsigned as a pipelined binary tree with LVL register levels plus one output register.
- Level i adds adjacent pairs from level i-1.
- An unpaired odd element is registered through unchanged.
REQ-016 Each level SHALL widen by 1 bit so that no intermediate carry is lost.
REQ-017 Handshake: advance = !out_valid || out_ready; in_ready = advance.
- A vector is accepted when in_valid && in_ready.
REQ-018 When advance = 1, every stage (data and valid bit) SHALL shift one level; when advance = 0, all stages SHALL hold.
REQ-019 Stage valid bits SHALL propagate bubbles.
- A cycle with in_valid = 0 and advance = 1 inserts a bubble.
- No vector is ever duplicated or dropped.
REQ-020 Latency from acceptance to out_valid SHALL be exactly LAT cycles when out_ready is continuously high, e.g. LAT = 4 for N_OPS = 6.
REQ-021 Throughput SHALL be one vector per cycle with out_ready high; results SHALL emerge in acceptance order.
REQ-022 OUT_MODE 0: result = full sum on all RW bits.
REQ-023 OUT_MODE 1: result[WIDTH-1:0] = sum mod 2**WIDTH, with the upper bits 0.
REQ-024 OUT_MODE 2: result[WIDTH-1:0] = min(sum, 2**WIDTH-1), with the upper bits 0.
REQ-025 overflow SHALL be registered alongside result and SHALL be meaningful only while out_valid = 1.
- overflow is 0 whenever out_valid = 0.
REQ-026 While out_valid = 1 and out_ready = 0, result and overflow SHALL remain stable until the handshake completes.
REQ-027 in_data SHALL be sampled only on an accepted cycle; changes to in_data while in_ready = 0 SHALL have no effect.

Reset
REQ-028 While rst = 1 at a clock edge, all stage valid bits SHALL be cleared to 0.
- out_valid = 0, result = 0, overflow = 0 on the following cycle.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight vectors.
- No partial or stale result appears after reset is released.
REQ-031 An input presented in the same cycle as rst = 1 SHALL NOT be accepted.

Verification
REQ-032 Basic: N_OPS=6, WIDTH=16, OUT_MODE=0, operands 0,1,2,3,4,5 -> out_valid high 4 cycles later, result = 19'd15, overflow = 0.
REQ-033 Width modes: six operands of 16'hFFFF, full sum 0x5FFFA.
- OUT_MODE 0 -> result 19'h5FFFA, overflow 0.
- OUT_MODE 1 -> result 19'h0FFFA, overflow 1.
- OUT_MODE 2 -> result 19'h0FFFF, overflow 1.
REQ-034 Back-to-back: 10 consecutive random vectors, out_ready = 1 -> 10 consecutive results in order, each matching the reference-model sum, with no gaps.
REQ-035 Backpressure: out_ready held 0 for 5 cycles with the pipeline full -> in_ready = 0, result stable.
- After out_ready returns high, all results are delivered in order with none lost or duplicated.
REQ-036 Reset mid-flight: 3 vectors accepted, rst pulsed 1 cycle before the first emerges -> out_valid stays 0 until a new vector is accepted.
- The new vector's result then appears LAT cycles later.
REQ-037 Odd and minimum size: N_OPS=3 with operands 1,2,4 gives result 7 after 3 cycles; N_OPS=2 with operands 16'hFFFF,1 gives result 17'h10000 after 2 cycles.
